// File: rtl/ahb_modmul_n_if.sv
// AHB-Lite bus bundle between the peripheral interconnect and the modular multiplier slave.
interface ahb_modmul_n_if;
  logic        sHSEL;
  logic [31:0] sHADDR;
  logic [1:0]  sHTRANS;
  logic        sHWRITE;
  logic [2:0]  sHSIZE;
  logic [2:0]  sHBURST;
  logic [31:0] sHWDATA;
  logic [31:0] sHRDATA;
  logic [1:0]  sHRESP;
  logic        sHREADYin;
  logic        sHREADYout;

  modport master (
    output sHSEL, sHADDR, sHTRANS, sHWRITE, sHSIZE, sHBURST, sHWDATA, sHREADYin,
    input  sHRDATA, sHRESP, sHREADYout
  );
  modport slave (
    input  sHSEL, sHADDR, sHTRANS, sHWRITE, sHSIZE, sHBURST, sHWDATA, sHREADYin,
    output sHRDATA, sHRESP, sHREADYout
  );
endinterface

// File: rtl/ahb_modmul_n.sv
// AHB-Lite slave computing R = (A*B) mod M, one multiplier bit per cycle (interleaved shift/subtract).
// Optional AHB_MODMUL_IRQ_EN adds the CTRL.IE bit and a registered IRQ = IE & DONE output.
module ahb_modmul_n #(
  parameter int WIDTH = 256
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_modmul_n_if.slave bus
`ifdef AHB_MODMUL_IRQ_EN
  ,
  output logic          IRQ
`endif
);
  localparam int NW = WIDTH / 32;
  localparam int DW = WIDTH + 2;
  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CHECK, RUN} state_t;
  state_t state_q, state_d;

  logic             dp_vld, dp_wr, dp_bad, err2_q;
  logic [11:2]      dp_addr;
  logic [3:0]       dp_rgn;
  logic [5:0]       dp_idx;
  logic [WIDTH-1:0] a_q, b_q, m_q, r_q, acc_q;
  logic [KW-1:0]    k_q;
  logic             done_q, err_q;
  logic             addr_acc, busy, err1, r_stall, wr_en, rd_en, ctrl_wr, stat_wr, start, chk_bad;
  logic [DW-1:0]    t0, t1, t2, m_x;
  logic [31:0]      rdata, ctrl_rd;
  logic             unused_ok;

  function automatic logic [31:0] word_sel(input logic [WIDTH-1:0] v, input logic [5:0] idx);
    word_sel = '0;
    for (int i = 0; i < NW; i++)
      if (idx == 6'(i)) word_sel = v[i*32 +: 32];
  endfunction

  assign addr_acc = bus.sHSEL & bus.sHTRANS[1] & bus.sHREADYin;
  assign dp_rgn   = dp_addr[11:8];
  assign dp_idx   = dp_addr[7:2];
  assign busy     = (state_q != IDLE);
  // First cycle of a size error stalls; err2_q marks the second (ready) cycle.
  assign err1     = dp_vld & dp_bad & ~err2_q;
  assign r_stall  = dp_vld & ~dp_wr & ~dp_bad & (dp_rgn == 4'h4) & busy;
  assign wr_en    = dp_vld & dp_wr & ~dp_bad;
  assign rd_en    = dp_vld & ~dp_wr & ~dp_bad & ~r_stall;
  assign ctrl_wr  = wr_en & (dp_addr == 10'h000);
  assign stat_wr  = wr_en & (dp_addr == 10'h001);
  assign start    = ctrl_wr & bus.sHWDATA[0];
  assign chk_bad  = (m_q == '0) | (b_q >= m_q);

  assign bus.sHREADYout = ~(err1 | r_stall);
  assign bus.sHRESP     = (err1 | err2_q) ? 2'b01 : 2'b00;
  assign bus.sHRDATA    = rdata;

`ifdef AHB_MODMUL_IRQ_EN
  logic ie_q;
  assign ctrl_rd = {30'b0, ie_q, 1'b0};
`else
  assign ctrl_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (dp_rgn)
        4'h0: begin
          case (dp_idx)
            6'd0:    rdata = ctrl_rd;
            6'd1:    rdata = {29'b0, err_q, done_q, busy};
            6'd2:    rdata = 32'(WIDTH);
            default: rdata = '0;
          endcase
        end
        4'h1:    rdata = word_sel(a_q, dp_idx);
        4'h2:    rdata = word_sel(b_q, dp_idx);
        4'h3:    rdata = word_sel(m_q, dp_idx);
        4'h4:    rdata = word_sel(r_q, dp_idx);
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CHECK;
      CHECK:   state_d = chk_bad ? IDLE : RUN;
      RUN:     if (k_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // acc < M and B < M keep 2*acc + B below 3M, so two trial subtracts suffice.
  always_comb begin
    m_x = DW'(m_q);
    t0  = DW'({acc_q, 1'b0}) + (a_q[k_q] ? DW'(b_q) : '0);
    t1  = (t0 >= m_x) ? t0 - m_x : t0;
    t2  = (t1 >= m_x) ? t1 - m_x : t1;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      dp_vld  <= 1'b0;
      dp_wr   <= 1'b0;
      dp_bad  <= 1'b0;
      dp_addr <= '0;
      err2_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err2_q  <= err1;
      if (bus.sHREADYout) begin
        dp_vld  <= addr_acc;
        dp_wr   <= bus.sHWRITE;
        dp_bad  <= (bus.sHSIZE != 3'b010);
        dp_addr <= bus.sHADDR[11:2];
      end
      if (wr_en && !busy) begin
        for (int i = 0; i < NW; i++) begin
          if (dp_idx == 6'(i)) begin
            case (dp_rgn)
              4'h1:    a_q[i*32 +: 32] <= bus.sHWDATA;
              4'h2:    b_q[i*32 +: 32] <= bus.sHWDATA;
              4'h3:    m_q[i*32 +: 32] <= bus.sHWDATA;
              default: ;
            endcase
          end
        end
      end
      if (stat_wr) begin
        if (bus.sHWDATA[1]) done_q <= 1'b0;
        if (bus.sHWDATA[2]) err_q  <= 1'b0;
      end
      // Completion below is assigned after the W1C so a same-cycle set wins.
      case (state_q)
        IDLE: if (start) begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
        CHECK: begin
          if (chk_bad) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else begin
            acc_q <= '0;
            k_q   <= KW'(WIDTH - 1);
          end
        end
        RUN: begin
          acc_q <= t2[WIDTH-1:0];
          k_q   <= k_q - KW'(1);
          if (k_q == '0) begin
            r_q    <= t2[WIDTH-1:0];
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AHB_MODMUL_IRQ_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ie_q <= 1'b0;
      IRQ  <= 1'b0;
    end else begin
      if (ctrl_wr) ie_q <= bus.sHWDATA[1];
      IRQ <= ie_q & done_q;
    end
  end
`endif

  assign unused_ok = ^{bus.sHADDR[31:12], bus.sHADDR[1:0], bus.sHTRANS[0], bus.sHBURST, t2[DW-1:WIDTH]};
endmodule

// File: tb/tb_ahb_modmul_n.sv
// Scoreboard bench for ahb_modmul_n at WIDTH=64: reads push expected data, completed data phases pop and compare.
`timescale 1ns/1ps
module tb_ahb_modmul_n;
  localparam int WIDTH = 64;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] exp_q[$];

  ahb_modmul_n_if bus();
  assign bus.sHREADYin = bus.sHREADYout;

`ifdef AHB_MODMUL_IRQ_EN
  logic IRQ;
`endif

  ahb_modmul_n #(.WIDTH(WIDTH)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
`ifdef AHB_MODMUL_IRQ_EN
    ,
    .IRQ     (IRQ)
`endif
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mm(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
    logic [127:0] p;
    p = {64'b0, a} * {64'b0, b};
    return 64'(p % {64'b0, m});
  endfunction

  // Called at #1 after a rising edge; returns #1 after the edge ending the data phase.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd, input logic [2:0] sz,
                      output logic [31:0] rd, output logic [1:0] resp0, output logic [1:0] resp1,
                      output int waits, output int dcyc);
    bus.sHSEL = 1'b1; bus.sHTRANS = 2'b10; bus.sHADDR = {20'h0, addr}; bus.sHWRITE = wr; bus.sHSIZE = sz;
    @(posedge HCLK); #1;
    bus.sHSEL = 1'b0; bus.sHTRANS = 2'b00; bus.sHWDATA = wd;
    dcyc = cyc; resp0 = bus.sHRESP; waits = 0;
    while (!bus.sHREADYout && waits < 5000) begin
      @(posedge HCLK); #1;
      waits++;
    end
    if (!bus.sHREADYout) chk("xfer_timeout", 64'(bus.sHREADYout), 64'd1);
    rd = bus.sHRDATA; resp1 = bus.sHRESP;
    @(posedge HCLK); #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] d, output int dcyc);
    logic [31:0] rd; logic [1:0] r0, r1; int w;
    xfer(1'b1, addr, d, 3'b010, rd, r0, r1, w, dcyc);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic [1:0] r0, r1; int w, dc;
    exp_q.push_back(exp);
    xfer(1'b0, addr, 32'h0, 3'b010, rd, r0, r1, w, dc);
    chk(tag, 64'(rd), 64'(exp_q.pop_front()));
  endtask

  task automatic rd_r(input string tag, input logic [63:0] exp);
    rd_chk({tag, "_r0"}, 12'h400, exp[31:0]);
    rd_chk({tag, "_r1"}, 12'h404, exp[63:32]);
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
    int dc;
    wr(12'h100, a[31:0], dc); wr(12'h104, a[63:32], dc);
    wr(12'h200, b[31:0], dc); wr(12'h204, b[63:32], dc);
    wr(12'h300, m[31:0], dc); wr(12'h304, m[63:32], dc);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge HCLK); #1;
    end
  endtask

  // START write with an R[0] read address pipelined into its data phase.
  task automatic start_rd_r0(input logic [31:0] exp);
    int waits;
    exp_q.push_back(exp);
    bus.sHSEL = 1'b1; bus.sHTRANS = 2'b10; bus.sHADDR = 32'h0; bus.sHWRITE = 1'b1; bus.sHSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus.sHWDATA = 32'h1; bus.sHADDR = 32'h400; bus.sHWRITE = 1'b0;
    @(posedge HCLK); #1;
    bus.sHSEL = 1'b0; bus.sHTRANS = 2'b00;
    waits = 0;
    while (!bus.sHREADYout && waits < 5000) begin
      @(posedge HCLK); #1;
      waits++;
    end
    chk("rstall_waits", 64'(waits), 64'd65);
    chk("rstall_resp", 64'(bus.sHRESP), 64'd0);
    chk("rstall_data", 64'(bus.sHRDATA), 64'(exp_q.pop_front()));
    @(posedge HCLK); #1;
  endtask

  initial begin
    logic [63:0] prev, big, bm;
    logic [31:0] rd;
    logic [1:0]  r0, r1;
    int s, w, dc;

    bus.sHSEL = 1'b0; bus.sHTRANS = 2'b00; bus.sHADDR = '0; bus.sHWRITE = 1'b0;
    bus.sHSIZE = 3'b010; bus.sHBURST = 3'b000; bus.sHWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Reset state and static registers
    chk("rst_ready", 64'(bus.sHREADYout), 64'd1);
    chk("rst_resp", 64'(bus.sHRESP), 64'd0);
    chk("rst_rdata", 64'(bus.sHRDATA), 64'd0);
    rd_chk("rst_status", 12'h004, 32'h0);
    rd_chk("rst_ctrl", 12'h000, 32'h0);
    rd_r("rst", 64'h0);
    rd_chk("width", 12'h008, 32'd64);
    wr(12'h500, 32'hDEAD_BEEF, dc);
    rd_chk("unmapped", 12'h500, 32'h0);
    wr(12'h108, 32'h55, dc);
    rd_chk("a_beyond_nw", 12'h108, 32'h0);

    // Small operands: busy one cycle before completion, then result
    load(64'd5, 64'd7, 64'd11);
    rd_chk("a0_readback", 12'h100, 32'd5);
    wr(12'h000, 32'h1, s);
    wait_cyc(s + 64);
    rd_chk("t1_busy_c65", 12'h004, 32'h1);
    rd_chk("t1_done", 12'h004, 32'h2);
    rd_r("t1", mm(64'd5, 64'd7, 64'd11));
    wr(12'h004, 32'h2, dc);

    // Full-width operands, A >= M
    bm = 64'hFFFF_FFFF_FFFF_FFC5;
    load(64'hFFFF_FFFF_FFFF_FFFF, bm - 64'd1, bm);
    wr(12'h000, 32'h1, s);
    wait_cyc(s + 70);
    rd_chk("t2_done", 12'h004, 32'h2);
    prev = mm(64'hFFFF_FFFF_FFFF_FFFF, bm - 64'd1, bm);
    rd_r("t2", prev);
    wr(12'h004, 32'h2, dc);

    // B == M: error path at cycle 2, R untouched
    load(64'd5, 64'd11, 64'd11);
    wr(12'h000, 32'h1, s);
    wait_cyc(s + 1);
    rd_chk("t3_err_c2", 12'h004, 32'h6);
    rd_r("t3_keep", prev);
    wr(12'h004, 32'h6, dc);
    rd_chk("t3_w1c", 12'h004, 32'h0);

    // R read right after START stalls until the new result exists
    load(64'd9, 64'd10, 64'd13);
    start_rd_r0(32'(mm(64'd9, 64'd10, 64'd13)));
    rd_chk("t4_done", 12'h004, 32'h2);
    wr(12'h004, 32'h2, dc);

    // Byte-size write: two-cycle ERROR, no side effect
    xfer(1'b1, 12'h100, 32'hAA, 3'b000, rd, r0, r1, w, dc);
    chk("t5_err_resp0", 64'(r0), 64'd1);
    chk("t5_err_waits", 64'(w), 64'd1);
    chk("t5_err_resp1", 64'(r1), 64'd1);
    rd_chk("t5_a0_kept", 12'h100, 32'd9);

    // START and operand write during BUSY are ignored
    big = 64'h0123_4567_89AB_CDEF;
    load(big, 64'h0FED_CBA9_8765_4321, 64'hF000_0000_0000_0061);
    wr(12'h000, 32'h1, s);
    wr(12'h000, 32'h1, dc);
    wr(12'h100, 32'hFFFF, dc);
    wait_cyc(s + 65);
    rd_chk("t5_done_c66", 12'h004, 32'h2);
    rd_r("t5", mm(big, 64'h0FED_CBA9_8765_4321, 64'hF000_0000_0000_0061));
    rd_chk("t5_a0_busy_wr", 12'h100, big[31:0]);

    // Reset mid-RUN, then a clean run with IE requested
    load(64'd123, 64'd45, 64'd1000);
    wr(12'h000, 32'h1, s);
    wait_cyc(s + 20);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd_chk("t6_status", 12'h004, 32'h0);
    rd_r("t6_rst", 64'h0);
    rd_chk("t6_a0", 12'h100, 32'h0);
`ifdef AHB_MODMUL_IRQ_EN
    chk("t6_irq_rst", 64'(IRQ), 64'd0);
`endif
    load(64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444, 64'h8000_0000_0000_001D);
    wr(12'h000, 32'h3, s);
    wait_cyc(s + 66);
    rd_chk("t6_done", 12'h004, 32'h2);
    rd_r("t6", mm(64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444, 64'h8000_0000_0000_001D));
`ifdef AHB_MODMUL_IRQ_EN
    rd_chk("t6_ctrl_ie", 12'h000, 32'h2);
    chk("t6_irq_hi", 64'(IRQ), 64'd1);
`else
    rd_chk("t6_ctrl_noie", 12'h000, 32'h0);
`endif
    wr(12'h004, 32'h2, dc);
    repeat (2) begin
      @(posedge HCLK); #1;
    end
`ifdef AHB_MODMUL_IRQ_EN
    chk("t6_irq_lo", 64'(IRQ), 64'd0);
`endif
    rd_chk("t6_w1c", 12'h004, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
